vi_rst_seq_ctrl: RTL and testbench
==================================

// Module: vi_rst_seq_ctrl
// PURPOSE
//  Sequences staged reset deassertion for NUM_STG sub-blocks in clock domain B.
//  On power-up or on a synchronised soft-reset pulse, holds every stage in reset,
//  then releases the stages one by one, in index order 0..NUM_STG-1.
//  Before releasing the next stage, it waits for the current stage's ready/ack, with a timeout.
//  The soft-reset request comes from a control-register pulse already transferred into clk_b.
// PARAMETERS
//  NUM_STG   4    number of reset stages/outputs (>=1)
//  HOLD_CYC  64   cycles all stages are held in reset before stage 0 is released (>=1)
//  GAP_CYC   16   idle cycles between an ack/timeout and release of the next stage (>=0)
//  TMO_W     16   width of the timeout limit input
// PORTS
//  clk_b        in   1        clock, domain B
//  rst_b_n      in   1        reset, asynchronous, active-low
//  sw_rst_req   in   1        1-cycle soft-reset request, synchronous to clk_b
//  stg_ack      in   NUM_STG  per-stage ready (level); stage i is sampled only while waiting on i
//  tmo_limit    in   TMO_W    ack-wait timeout in cycles; 0 = no wait (ack ignored)
//  stg_rst_n    out  NUM_STG  per-stage active-low reset, registered
//  seq_busy     out  1        1 while sequencing (every state except DONE)
//  seq_done     out  1        1 in DONE: all stages released
//  tmo_err      out  1        1-cycle pulse: current stage ack timed out
//  tmo_stg      out  clog2(NUM_STG) (min 1)  index of the most recently timed-out stage
// BEHAVIOUR
//  Reset values: stg_rst_n=0, seq_busy=1, seq_done=0, tmo_err=0, tmo_stg=0.
//   - After reset, the FSM is in HOLD with the counter at 0, so a sequence starts automatically.
//  FSM: HOLD -> REL -> WAIT -> GAP -> REL ... -> DONE. One shared counter (cnt) is used.
//   - cnt width is max(TMO_W, clog2(max(HOLD_CYC,GAP_CYC)+1)).
//   - cnt clears on every state entry.
//  HOLD:
//   - stg_rst_n = all 0; cnt increments each cycle.
//   - When cnt==HOLD_CYC-1: go to REL with stage index s=0.
//   - Result: stg_rst_n[0] rises exactly HOLD_CYC cycles after the first all-low cycle.
//  REL:
//   - stg_rst_n[s] is set to 1 on entry.
//   - Stages < s stay 1; stages > s stay 0.
//   - One cycle in REL, then WAIT.
//  WAIT:
//   - If tmo_limit==0: leave immediately.
//   - If stg_ack[s]==1 is sampled: leave. An ack already high on WAIT entry exits after 1 cycle.
//   - Else, if cnt==tmo_limit-1: tmo_err=1 for this cycle, tmo_stg<=s, then leave.
//     The sequence continues; a timeout never aborts it.
//   - Leaving WAIT: if s==NUM_STG-1, go to DONE; else if GAP_CYC==0, go to REL with s+1; else go to GAP.
//  GAP:
//   - cnt counts up to GAP_CYC-1, then REL with s+1.
//  DONE:
//   - stg_rst_n = all 1; seq_done=1, seq_busy=0.
//   - Stays in DONE until sw_rst_req.
//  sw_rst_req:
//   - Highest priority, accepted in ANY state, including HOLD and mid-WAIT.
//   - Next cycle: state=HOLD, cnt=0, stg_rst_n all 0, seq_done=0, seq_busy=1.
//   - A request during HOLD restarts the full HOLD_CYC count.
//   - A request in the same cycle as an ack or timeout wins: no tmo_err pulse that cycle, no stage release.
//  tmo_stg:
//   - Not cleared by sw_rst_req; it is overwritten only by the next timeout.
//  stg_ack:
//   - Bits other than s, and all bits outside WAIT, are ignored.
//   - An ack that drops after release has no effect.
//  All outputs are registered and glitch-free.
//  rst_b_n assertion mid-sequence forces the reset values asynchronously.
// TESTING
//  1. Release rst_b_n, acks tied high:
//     - stg_rst_n[0] rises at cycle 64.
//     - stg_rst_n[1..3] rise at a 1+1+16 = 18-cycle pitch.
//     - seq_done follows release of stage 3.
//  2. tmo_limit=100, stg_ack[2] held low:
//     - tmo_err pulses once, 100 cycles into stage-2 WAIT, and tmo_stg=2.
//     - Stage 3 still releases; seq_done=1.
//  3. In DONE, pulse sw_rst_req:
//     - Next cycle: stg_rst_n=4'b0000, seq_busy=1.
//     - The full 64-cycle hold and the sequence then repeat.
//  4. Pulse sw_rst_req at cycle 30 of HOLD:
//     - stg_rst_n[0] first rises 64 cycles after the request, not at cycle 64.
//  5. Assert sw_rst_req in the same cycle stg_ack[1] rises in WAIT:
//     - HOLD is entered; stage 2 is not released; no tmo_err.
//  6. tmo_limit=0, stg_ack=0, GAP_CYC=0:
//     - Stages release on consecutive 2-cycle steps (REL, WAIT).
//     - tmo_err never asserts.

Source files
------------

// File: rtl/vi_rst_seq_ctrl.sv
// Staged reset-release sequencer for clock domain B.
// Holds all sub-block resets low, then releases stage 0..NUM_STG-1 in order.
// After each release it waits for that stage's ack, bounded by a timeout,
// and then idles for a gap before releasing the next stage.
// A soft-reset request restarts the whole sequence from HOLD.
module vi_rst_seq_ctrl #(
  parameter int NUM_STG  = 4,
  parameter int HOLD_CYC = 64,
  parameter int GAP_CYC  = 16,
  parameter int TMO_W    = 16,
  localparam int STG_W   = (NUM_STG > 1) ? $clog2(NUM_STG) : 1
) (
  input  logic               clk_b,
  input  logic               rst_b_n,
  input  logic               sw_rst_req,
  input  logic [NUM_STG-1:0] stg_ack,
  input  logic [TMO_W-1:0]   tmo_limit,
  output logic [NUM_STG-1:0] stg_rst_n,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               tmo_err,
  output logic [STG_W-1:0]   tmo_stg
);

  // The counter serves HOLD, WAIT and GAP, so it is sized for the largest of them.
  localparam int HG_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int HG_W   = $clog2(HG_MAX + 1);
  localparam int CNT_W  = (TMO_W > HG_W) ? TMO_W : HG_W;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
  localparam logic [STG_W-1:0] LAST_STG  = STG_W'(NUM_STG - 1);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_REL,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [STG_W-1:0] stg;
  logic [STG_W-1:0] stg_nxt;
  logic [TMO_W-1:0] tmo_last;
  logic             wait_skip;
  logic             wait_ack;
  logic             wait_tmo;
  logic             wait_exit;

  // Reset pattern with stages 0..s released and the rest still held.
  function automatic logic [NUM_STG-1:0] rel_mask(input logic [STG_W-1:0] s);
    logic [NUM_STG-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STG; i++) begin
      m[i] = (i <= int'(s));
    end
    return m;
  endfunction

  // WAIT exit conditions: a zero limit skips the wait, an ack wins over a timeout.
  always_comb begin
    stg_nxt   = stg + STG_W'(1);
    tmo_last  = tmo_limit - TMO_W'(1);
    wait_skip = (tmo_limit == '0);
    wait_ack  = stg_ack[stg];
    wait_tmo  = !wait_skip && !wait_ack && (cnt == CNT_W'(tmo_last));
    wait_exit = wait_skip || wait_ack || wait_tmo;
  end

  // Sequencer FSM with registered outputs; soft reset overrides every state.
  always_ff @(posedge clk_b or negedge rst_b_n) begin
    if (!rst_b_n) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      stg       <= '0;
      stg_rst_n <= '0;
      seq_busy  <= 1'b1;
      seq_done  <= 1'b0;
      tmo_err   <= 1'b0;
      tmo_stg   <= '0;
    end else begin
      tmo_err <= 1'b0;
      if (sw_rst_req) begin
        state     <= ST_HOLD;
        cnt       <= '0;
        stg       <= '0;
        stg_rst_n <= '0;
        seq_busy  <= 1'b1;
        seq_done  <= 1'b0;
      end else begin
        case (state)
          ST_HOLD: begin
            if (cnt == HOLD_LAST) begin
              state     <= ST_REL;
              cnt       <= '0;
              stg       <= '0;
              stg_rst_n <= rel_mask('0);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_REL: begin
            state <= ST_WAIT;
            cnt   <= '0;
          end
          ST_WAIT: begin
            if (wait_tmo) begin
              tmo_err <= 1'b1;
              tmo_stg <= stg;
            end
            if (wait_exit) begin
              cnt <= '0;
              if (stg == LAST_STG) begin
                state     <= ST_DONE;
                stg_rst_n <= '1;
                seq_busy  <= 1'b0;
                seq_done  <= 1'b1;
              end else if (GAP_CYC == 0) begin
                state     <= ST_REL;
                stg       <= stg_nxt;
                stg_rst_n <= rel_mask(stg_nxt);
              end else begin
                state <= ST_GAP;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (cnt == GAP_LAST) begin
              state     <= ST_REL;
              cnt       <= '0;
              stg       <= stg_nxt;
              stg_rst_n <= rel_mask(stg_nxt);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_DONE: begin
            cnt <= '0;
          end
          default: begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vi_rst_seq_ctrl.sv
// Directed bench for vi_rst_seq_ctrl: default instance (HOLD 64, GAP 16)
// plus a GAP_CYC=0 instance for back-to-back release stepping.
module tb_vi_rst_seq_ctrl;

  logic        clk_b   = 1'b0;
  logic        rst_b_n = 1'b0;
  logic        sw_rst_req;
  logic [3:0]  stg_ack;
  logic [15:0] tmo_limit;
  logic [3:0]  stg_rst_n;
  logic        seq_busy;
  logic        seq_done;
  logic        tmo_err;
  logic [1:0]  tmo_stg;

  logic        z_req;
  logic [3:0]  z_ack;
  logic [15:0] z_tmo;
  logic [3:0]  z_rst_n;
  logic        z_busy;
  logic        z_done;
  logic        z_err;
  logic [1:0]  z_stg;

  int n_chk = 0;
  int n_err = 0;
  int rise_at[4];
  int done_at;
  int tmo_at;
  int tmo_cnt;

  always #5 clk_b = ~clk_b;

  vi_rst_seq_ctrl #(.NUM_STG(4), .HOLD_CYC(64), .GAP_CYC(16), .TMO_W(16)) u_dut (
    .clk_b(clk_b), .rst_b_n(rst_b_n), .sw_rst_req(sw_rst_req), .stg_ack(stg_ack),
    .tmo_limit(tmo_limit), .stg_rst_n(stg_rst_n), .seq_busy(seq_busy),
    .seq_done(seq_done), .tmo_err(tmo_err), .tmo_stg(tmo_stg)
  );

  vi_rst_seq_ctrl #(.NUM_STG(4), .HOLD_CYC(8), .GAP_CYC(0), .TMO_W(16)) u_dut_z (
    .clk_b(clk_b), .rst_b_n(rst_b_n), .sw_rst_req(z_req), .stg_ack(z_ack),
    .tmo_limit(z_tmo), .stg_rst_n(z_rst_n), .seq_busy(z_busy),
    .seq_done(z_done), .tmo_err(z_err), .tmo_stg(z_stg)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Leaves the bench in the first HOLD cycle (cnt=0) after the request.
  task automatic pulse_req();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
  endtask

  // Walks the main instance from the current cycle (numbered 0) until seq_done.
  task automatic seq_watch(input int max_cyc);
    for (int i = 0; i < 4; i++) rise_at[i] = -1;
    done_at = -1;
    tmo_at  = -1;
    tmo_cnt = 0;
    for (int c = 0; c <= max_cyc; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (stg_rst_n[i] && rise_at[i] < 0) rise_at[i] = c;
      end
      if (tmo_err) begin
        tmo_cnt++;
        if (tmo_at < 0) tmo_at = c;
      end
      if (seq_done) begin
        done_at = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sw_rst_req = 1'b0;
    stg_ack    = 4'hF;
    tmo_limit  = 16'd100;
    z_req      = 1'b0;
    z_ack      = 4'h0;
    z_tmo      = 16'd0;

    // Reset state
    tick_n(3);
    chk("rst_stg_rst_n", int'(stg_rst_n), 0);
    chk("rst_busy", int'(seq_busy), 1);
    chk("rst_done", int'(seq_done), 0);
    chk("rst_tmo_err", int'(tmo_err), 0);
    chk("rst_tmo_stg", int'(tmo_stg), 0);

    // 1: power-up sequence, acks high
    rst_b_n = 1'b1;
    seq_watch(300);
    chk("t1_rise0", rise_at[0], 64);
    chk("t1_rise1", rise_at[1], 82);
    chk("t1_rise2", rise_at[2], 100);
    chk("t1_rise3", rise_at[3], 118);
    chk("t1_done", done_at, 120);
    chk("t1_busy", int'(seq_busy), 0);
    chk("t1_tmo_cnt", tmo_cnt, 0);
    chk("t1_tmo_stg", int'(tmo_stg), 0);

    // 3 + 2: soft reset from DONE, then stage 2 ack held low
    stg_ack = 4'b1011;
    pulse_req();
    chk("t3_stg_rst_n", int'(stg_rst_n), 0);
    chk("t3_busy", int'(seq_busy), 1);
    chk("t3_done", int'(seq_done), 0);
    seq_watch(400);
    chk("t2_rise0", rise_at[0], 64);
    chk("t2_rise2", rise_at[2], 100);
    chk("t2_tmo_at", tmo_at, 201);
    chk("t2_tmo_cnt", tmo_cnt, 1);
    chk("t2_tmo_stg", int'(tmo_stg), 2);
    chk("t2_rise3", rise_at[3], 217);
    chk("t2_done", done_at, 219);

    // 4: request 30 cycles into HOLD restarts the count
    stg_ack = 4'hF;
    pulse_req();
    chk("t4_tmo_stg_kept", int'(tmo_stg), 2);
    tick_n(30);
    chk("t4_hold_low", int'(stg_rst_n), 0);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    seq_watch(300);
    chk("t4_rise0", rise_at[0], 64);
    chk("t4_done", done_at, 120);

    // 5: request collides with stage-1 ack in WAIT
    stg_ack = 4'b0001;
    pulse_req();
    tick_n(90);
    chk("t5_pre_stg", int'(stg_rst_n), 3);
    chk("t5_pre_busy", int'(seq_busy), 1);
    stg_ack    = 4'b0011;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk("t5_stg_rst_n", int'(stg_rst_n), 0);
    chk("t5_tmo_err", int'(tmo_err), 0);
    chk("t5_busy", int'(seq_busy), 1);
    chk("t5_done", int'(seq_done), 0);
    stg_ack = 4'hF;
    seq_watch(300);
    chk("t5_rise0", rise_at[0], 64);
    chk("t5_after_done", done_at, 120);

    // 6: zero timeout, no acks, no gap (HOLD 8)
    z_req = 1'b1;
    tick();
    z_req = 1'b0;
    for (int i = 0; i < 4; i++) rise_at[i] = -1;
    done_at = -1;
    tmo_cnt = 0;
    for (int c = 0; c <= 60; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (z_rst_n[i] && rise_at[i] < 0) rise_at[i] = c;
      end
      if (z_err) tmo_cnt++;
      if (z_done) begin
        done_at = c;
        break;
      end
      tick();
    end
    chk("t6_rise0", rise_at[0], 8);
    chk("t6_rise1", rise_at[1], 10);
    chk("t6_rise2", rise_at[2], 12);
    chk("t6_rise3", rise_at[3], 14);
    chk("t6_done", done_at, 16);
    chk("t6_tmo_cnt", tmo_cnt, 0);

    // Asynchronous reset mid-sequence
    pulse_req();
    tick_n(70);
    chk("ar_pre_stg", int'(stg_rst_n), 1);
    #2;
    rst_b_n = 1'b0;
    #1;
    chk("ar_stg_rst_n", int'(stg_rst_n), 0);
    chk("ar_busy", int'(seq_busy), 1);
    chk("ar_z_done", int'(z_done), 0);
    tick();
    rst_b_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
